// File: rtl/lif_spike_receiver.sv
// Leaky integrate-and-fire receiver: integrates weighted spikes from two
// synapse lines into a membrane potential with shift-based leak. It emits a
// one-cycle spike on threshold crossing and then ignores its inputs for a
// programmable refractory period.
module lif_spike_receiver #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned LEAK_SHIFT = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             spike_in_a,
  input  logic             spike_in_b,
  input  logic             cfg_wr,
  input  logic [1:0]       cfg_addr,
  input  logic [WIDTH-1:0] cfg_data,
  output logic             spike_out,
  output logic [WIDTH-1:0] potential,
  output logic             busy,
  output logic [7:0]       spike_count
);

  typedef enum logic {
    INTEGRATE = 1'b0,
    REFRACT   = 1'b1
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] v;
  logic [3:0]       cnt;

  logic [WIDTH-1:0] weight_a;
  logic [WIDTH-1:0] weight_b;
  logic [WIDTH-1:0] threshold;
  logic [3:0]       refr;

  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] leak;
  logic [WIDTH+1:0] sum;
  logic [WIDTH-1:0] sum_sat;
  logic             fire;

  // Next-potential datapath: leak never rounds to zero while V is non-zero,
  // so V always decays fully; the two extra bits catch overflow for saturation.
  always_comb begin
    shifted = v >> LEAK_SHIFT;
    leak    = shifted;
    if ((v != '0) && (shifted == '0)) begin
      leak = {{(WIDTH-1){1'b0}}, 1'b1};
    end
    sum = {2'b00, v} - {2'b00, leak};
    if (spike_in_a) begin
      sum = sum + {2'b00, weight_a};
    end
    if (spike_in_b) begin
      sum = sum + {2'b00, weight_b};
    end
    sum_sat = (sum[WIDTH+1:WIDTH] != 2'b00) ? '1 : sum[WIDTH-1:0];
    fire    = (sum_sat >= threshold);
  end

  // Configuration registers: writable in any state, even with ena low.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      weight_a  <= WIDTH'(16);
      weight_b  <= WIDTH'(16);
      threshold <= WIDTH'(64);
      refr      <= 4'd4;
    end else if (cfg_wr) begin
      case (cfg_addr)
        2'd0: weight_a  <= cfg_data;
        2'd1: weight_b  <= cfg_data;
        2'd2: threshold <= cfg_data;
        2'd3: refr      <= cfg_data[3:0];
        default: ;
      endcase
    end
  end

  // Integrate/refractory FSM with registered spike, busy and fire counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= INTEGRATE;
      v           <= '0;
      cnt         <= '0;
      spike_out   <= 1'b0;
      busy        <= 1'b0;
      spike_count <= '0;
    end else begin
      spike_out <= 1'b0;
      if (ena) begin
        case (state)
          INTEGRATE: begin
            if (fire) begin
              spike_out   <= 1'b1;
              v           <= '0;
              spike_count <= spike_count + 8'd1;
              // refr=0 means no dead time: remain integrating and refire freely
              if (refr != 4'd0) begin
                state <= REFRACT;
                cnt   <= refr;
                busy  <= 1'b1;
              end
            end else begin
              v <= sum_sat;
            end
          end
          REFRACT: begin
            v   <= '0;
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1) begin
              state <= INTEGRATE;
              busy  <= 1'b0;
            end
          end
          default: state <= INTEGRATE;
        endcase
      end
    end
  end

  assign potential = v;

endmodule
